bcd_counter_n: RTL and testbench

Parametrised N-digit BCD up/down counter. It replaces the fixed two-digit cascaded count-up counter, and adds direction control, parallel load, a wrap/saturate mode and a boundary pulse. The digit ripple condition is qualified by the count enable, so higher digits advance only on a real count event. It sits in the display/counting datapath and feeds 7-segment decoders or a timer supervisor.

---
 rtl/bcd_counter_n.sv | 73 +++++++
 tb/tb_bcd_counter_n.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit BCD up/down counter with parallel load, wrap/saturate boundary and status pulses
module bcd_counter_n #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  x,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bnd,
    output logic                  load_err
);
    logic [DIGITS-1:0][3:0] digits_q, digits_d;
    logic                   bnd_q, bnd_d;
    logic                   load_err_q, load_err_d;
    logic                   all9, all0, load_ok, ripple;

    // Detect the all-9s / all-0s boundaries and whether every load nibble is a legal BCD digit
    always_comb begin
        all9    = 1'b1;
        all0    = 1'b1;
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all9    = all9 & (digits_q[i] == 4'd9);
            all0    = all0 & (digits_q[i] == 4'd0);
            load_ok = load_ok & (load_val[4*i +: 4] <= 4'd9);
        end
    end

    // Next state: load beats count; the digit ripple only moves while a count step is active
    always_comb begin
        digits_d   = digits_q;
        bnd_d      = 1'b0;
        load_err_d = 1'b0;
        ripple     = 1'b1;
        if (load) begin
            if (load_ok)
                digits_d = load_val;
            else
                load_err_d = 1'b1;
        end else if (x) begin
            bnd_d = up ? all9 : all0;
            if (WRAP || !bnd_d) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (ripple)
                        digits_d[i] = up ? ((digits_q[i] == 4'd9) ? 4'd0 : digits_q[i] + 4'd1)
                                         : ((digits_q[i] == 4'd0) ? 4'd9 : digits_q[i] - 4'd1);
                    ripple = ripple & (up ? (digits_q[i] == 4'd9) : (digits_q[i] == 4'd0));
                end
            end
        end
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q   <= '0;
            bnd_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            bnd_q      <= bnd_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd_out  = digits_q;
    assign bnd      = bnd_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed and randomized checks of bcd_counter_n against an integer reference model
module tb_bcd_counter_n;
    logic        clk = 1'b0;
    logic        reset = 1'b1, x = 1'b0, up = 1'b0, load = 1'b0;
    logic [7:0]  lv2 = '0;
    logic [15:0] lv4 = '0;
    logic [7:0]  out_w, out_s;
    logic [15:0] out_4;
    logic        bnd_w, bnd_s, bnd_4, err_w, err_s, err_4;
    int          n_checks = 0, n_fail = 0;
    int          mw = 0, ms = 0, m4 = 0;
    bit          mbw, mbs, mb4, mew, mes, me4;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .x(x), .up(up), .load(load), .load_val(lv2),
        .bcd_out(out_w), .bnd(bnd_w), .load_err(err_w));
    bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .x(x), .up(up), .load(load), .load_val(lv2),
        .bcd_out(out_s), .bnd(bnd_s), .load_err(err_s));
    bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_d4 (
        .clk(clk), .reset(reset), .x(x), .up(up), .load(load), .load_val(lv4),
        .bcd_out(out_4), .bnd(bnd_4), .load_err(err_4));

    // Reference: counter value kept as a plain integer in 0..10^d-1
    task automatic model_step(input int d, input bit wrap, input int cur, input logic [15:0] lv,
                              input logic r, input logic l, input logic xx, input logic uu,
                              output int nxt, output bit b, output bit e);
        int maxv = 1;
        int val = 0;
        int p = 1;
        bit ok = 1'b1;
        for (int i = 0; i < d; i++) maxv *= 10;
        maxv -= 1;
        for (int i = 0; i < d; i++) begin
            if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
            val += int'(lv[4*i +: 4]) * p;
            p *= 10;
        end
        nxt = cur; b = 1'b0; e = 1'b0;
        if (r) nxt = 0;
        else if (l) begin
            if (ok) nxt = val; else e = 1'b1;
        end else if (xx) begin
            if (uu) begin
                if (cur == maxv) begin b = 1'b1; nxt = wrap ? 0 : cur; end
                else nxt = cur + 1;
            end else begin
                if (cur == 0) begin b = 1'b1; nxt = wrap ? maxv : 0; end
                else nxt = cur - 1;
            end
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick(input logic r, input logic l, input logic xx, input logic uu,
                        input logic [7:0] v2, input logic [15:0] v4);
        reset = r; load = l; x = xx; up = uu; lv2 = v2; lv4 = v4;
        @(posedge clk);
        model_step(2, 1'b1, mw, {8'h00, v2}, r, l, xx, uu, mw, mbw, mew);
        model_step(2, 1'b0, ms, {8'h00, v2}, r, l, xx, uu, ms, mbs, mes);
        model_step(4, 1'b1, m4, v4, r, l, xx, uu, m4, mb4, me4);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 8'h00, 16'h0000);
        tick(1, 0, 0, 0, 8'h00, 16'h0000);
        n_checks++;
        if ({out_w, out_s, out_4} !== 32'h0) begin
            n_fail++; $display("FAIL reset_value: got %h %h %h expected 00 00 0000", out_w, out_s, out_4);
        end
        n_checks++;
        if ({bnd_w, bnd_s, bnd_4, err_w, err_s, err_4} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {bnd_w, bnd_s, bnd_4, err_w, err_s, err_4});
        end
    endtask

    task automatic test_count_up();
        logic [15:0] e;
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0, 1, 1, 8'h00, 16'h0000);
            e = to_bcd(i);
            n_checks++;
            if (out_w !== e[7:0] || bnd_w !== 1'b0) begin
                n_fail++; $display("FAIL count_up step %0d: got %h bnd %b expected %h bnd 0", i, out_w, bnd_w, e[7:0]);
            end
            n_checks++;
            if (out_w[7:4] !== ((i >= 10) ? 4'd1 : 4'd0)) begin
                n_fail++; $display("FAIL count_up_digit1 step %0d: got %0d", i, out_w[7:4]);
            end
        end
    endtask

    task automatic test_hold();
        tick(0, 1, 0, 0, 8'h98, 16'h0098);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 8'h00, 16'h0000);
            n_checks++;
            if (out_w !== 8'h98 || out_s !== 8'h98 || bnd_w !== 1'b0 || bnd_s !== 1'b0) begin
                n_fail++; $display("FAIL hold cycle %0d: got %h/%h bnd %b/%b expected 98 bnd 0", i, out_w, out_s, bnd_w, bnd_s);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ew [3] = '{8'h99, 8'h00, 8'h01};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        logic       sb [3] = '{1'b0, 1'b1, 1'b1};
        tick(0, 1, 0, 0, 8'h98, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 1, 8'h00, 16'h0000);
            n_checks++;
            if (out_w !== ew[i] || bnd_w !== eb[i]) begin
                n_fail++; $display("FAIL wrap step %0d: got %h bnd %b expected %h bnd %b", i, out_w, bnd_w, ew[i], eb[i]);
            end
            n_checks++;
            if (out_s !== 8'h99 || bnd_s !== sb[i]) begin
                n_fail++; $display("FAIL sat_up step %0d: got %h bnd %b expected 99 bnd %b", i, out_s, bnd_s, sb[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic       sb [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ew [3] = '{8'h00, 8'h99, 8'h98};
        tick(0, 1, 0, 0, 8'h01, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 8'h00, 16'h0000);
            n_checks++;
            if (out_s !== 8'h00 || bnd_s !== sb[i]) begin
                n_fail++; $display("FAIL sat_down step %0d: got %h bnd %b expected 00 bnd %b", i, out_s, bnd_s, sb[i]);
            end
            n_checks++;
            if (out_w !== ew[i]) begin
                n_fail++; $display("FAIL wrap_down step %0d: got %h expected %h", i, out_w, ew[i]);
            end
        end
    endtask

    task automatic test_load_err();
        logic [7:0] pw, ps;
        pw = out_w; ps = out_s;
        tick(0, 1, 1, 1, 8'h3A, 16'h0000);
        n_checks++;
        if (err_w !== 1'b1 || err_s !== 1'b1 || bnd_w !== 1'b0 || bnd_s !== 1'b0) begin
            n_fail++; $display("FAIL load_err_flag: err %b/%b bnd %b/%b expected err 1 bnd 0", err_w, err_s, bnd_w, bnd_s);
        end
        n_checks++;
        if (out_w !== pw || out_s !== ps) begin
            n_fail++; $display("FAIL load_err_hold: got %h/%h expected %h/%h", out_w, out_s, pw, ps);
        end
        tick(0, 1, 1, 1, 8'h42, 16'h0000);
        n_checks++;
        if (out_w !== 8'h42 || out_s !== 8'h42 || err_w !== 1'b0 || bnd_w !== 1'b0) begin
            n_fail++; $display("FAIL load_over_count: got %h/%h err %b expected 42 err 0", out_w, out_s, err_w);
        end
    endtask

    task automatic test_direction();
        tick(0, 0, 1, 1, 8'h00, 16'h0000);
        n_checks++;
        if (out_w !== 8'h43) begin
            n_fail++; $display("FAIL dir_up: got %h expected 43", out_w);
        end
        tick(0, 0, 1, 0, 8'h00, 16'h0000);
        n_checks++;
        if (out_w !== 8'h42) begin
            n_fail++; $display("FAIL dir_down: got %h expected 42", out_w);
        end
    endtask

    task automatic test_reset_priority();
        tick(1, 1, 1, 1, 8'h55, 16'h5555);
        n_checks++;
        if ({out_w, out_s, out_4} !== 32'h0 || {bnd_w, bnd_s, bnd_4, err_w, err_s, err_4} !== 6'b0) begin
            n_fail++; $display("FAIL reset_priority: got %h %h %h flags %b expected zeros", out_w, out_s, out_4,
                               {bnd_w, bnd_s, bnd_4, err_w, err_s, err_4});
        end
    endtask

    task automatic test_digits4();
        tick(0, 1, 0, 0, 8'h00, 16'h1000);
        tick(0, 0, 1, 0, 8'h00, 16'h0000);
        n_checks++;
        if (out_4 !== 16'h0999 || bnd_4 !== 1'b0) begin
            n_fail++; $display("FAIL d4_borrow: got %h bnd %b expected 0999 bnd 0", out_4, bnd_4);
        end
        tick(0, 1, 0, 0, 8'h00, 16'h0000);
        tick(0, 0, 1, 0, 8'h00, 16'h0000);
        n_checks++;
        if (out_4 !== 16'h9999 || bnd_4 !== 1'b1) begin
            n_fail++; $display("FAIL d4_wrap: got %h bnd %b expected 9999 bnd 1", out_4, bnd_4);
        end
    endtask

    task automatic test_random();
        logic [15:0] ew, es, e4;
        logic [7:0]  v2;
        logic [15:0] v4;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 3));
            v2 = (sel == 0) ? 8'h99 : (sel == 1) ? 8'h00 : 8'($urandom);
            v4 = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0001 : 16'($urandom);
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0),
                 1'($urandom), v2, v4);
            ew = to_bcd(mw); es = to_bcd(ms); e4 = to_bcd(m4);
            n_checks++;
            if (out_w !== ew[7:0] || bnd_w !== mbw || err_w !== mew) begin
                n_fail++; $display("FAIL rand_wrap %0d: got %h/%b/%b expected %h/%b/%b", n, out_w, bnd_w, err_w, ew[7:0], mbw, mew);
            end
            n_checks++;
            if (out_s !== es[7:0] || bnd_s !== mbs || err_s !== mes) begin
                n_fail++; $display("FAIL rand_sat %0d: got %h/%b/%b expected %h/%b/%b", n, out_s, bnd_s, err_s, es[7:0], mbs, mes);
            end
            n_checks++;
            if (out_4 !== e4 || bnd_4 !== mb4 || err_4 !== me4) begin
                n_fail++; $display("FAIL rand_d4 %0d: got %h/%b/%b expected %h/%b/%b", n, out_4, bnd_4, err_4, e4, mb4, me4);
            end
            n_checks++;
            if ((bnd_w & err_w) | (bnd_s & err_s) | (bnd_4 & err_4)) begin
                n_fail++; $display("FAIL rand_exclusive %0d: bnd and load_err both high", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_hold();
        test_wrap();
        test_saturate();
        test_load_err();
        test_direction();
        test_reset_priority();
        test_digits4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
